// File: rtl/sample_source_responder.sv
// ---------------------------------------------------------------------------
// sample_source_responder
//
// Responder end of the 4-phase req/ack sample interface feeding the
// resampling filter. Samples from an upstream valid/ready producer are
// buffered in a DEPTH-entry FIFO. Each filter request pops one sample into
// the held data register and raises ack until the request is withdrawn.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   wr_valid  in   producer has a sample on wr_data
//   wr_ready  out  FIFO can accept a sample this cycle (combinational)
//   wr_data   in   producer sample, bit 0 is MSB
//   req       in   filter request (filter req_in)
//   ack       out  responder acknowledge (filter ack_in), registered
//   data      out  sample answering the current request, registered
//   level     out  FIFO occupancy 0..DEPTH, registered
//   starve    out  request pending in IDLE with an empty FIFO (combinational)
// ---------------------------------------------------------------------------
module sample_source_responder #(
   parameter int DWIDTH    = 16,
   parameter int DEPTH     = 16,
   parameter int DEPTH_LOG = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_valid,
   output logic                 wr_ready,
   input  logic [0:DWIDTH-1]    wr_data,
   input  logic                 req,
   output logic                 ack,
   output logic [0:DWIDTH-1]    data,
   output logic [0:DEPTH_LOG]   level,
   output logic                 starve
);

   localparam logic [DEPTH_LOG:0] C_FULL = (DEPTH_LOG+1)'(DEPTH);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_ACK  = 1'b1
   } state_t;

   state_t                 r_state;
   logic                   r_ack;
   logic [0:DWIDTH-1]      r_data;
   logic [0:DWIDTH-1]      r_mem [DEPTH];
   logic [DEPTH_LOG-1:0]   r_wptr;
   logic [DEPTH_LOG-1:0]   r_rptr;
   logic [DEPTH_LOG:0]     r_level;

   logic                   w_push;
   logic                   w_pop;
   logic                   w_empty;

   assign w_empty  = (r_level == '0);
   assign wr_ready = !rst && (r_level != C_FULL);
   assign w_push   = wr_valid && wr_ready;
   // A pop is only ever taken from IDLE; the registered level means a sample
   // pushed on this same edge cannot answer the request (no fall-through).
   assign w_pop    = (r_state == S_IDLE) && req && !w_empty;
   assign starve   = (r_state == S_IDLE) && req && w_empty;

   assign ack   = r_ack;
   assign data  = r_data;
   assign level = r_level;

   // FIFO storage: contents are not reset, occupancy tracking makes stale
   // entries unreachable.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= wr_data;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Handshake FSM with registered ack/data. ACK is left only when req is
   // low, so exactly one sample is delivered per handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ack   <= 1'b0;
         r_data  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_data  <= r_mem[r_rptr];
                  r_ack   <= 1'b1;
                  r_state <= S_ACK;
               end
            end
            S_ACK: begin
               if (!req) begin
                  r_ack   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_ack   <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sample_source_responder.sv
// ---------------------------------------------------------------------------
// tb_sample_source_responder
//
// Directed bench for sample_source_responder: basic pull, starvation,
// full FIFO back-pressure, streaming across pointer wrap, held request and
// reset in the middle of a handshake.
// ---------------------------------------------------------------------------
module tb_sample_source_responder;

   logic          clk;
   logic          rst;
   logic          wr_valid;
   logic          wr_ready;
   logic [0:15]   wr_data;
   logic          req;
   logic          ack;
   logic [0:15]   data;
   logic [0:4]    level;
   logic          starve;

   int n_cmp;
   int n_err;

   sample_source_responder #(
      .DWIDTH    (16),
      .DEPTH     (16),
      .DEPTH_LOG (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_data  (wr_data),
      .req      (req),
      .ack      (ack),
      .data     (data),
      .level    (level),
      .starve   (starve)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs are then driven and outputs sampled 1 ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] val);
      wr_valid = 1'b1;
      wr_data  = val;
      tick();
      wr_valid = 1'b0;
   endtask

   // Full 4-phase handshake expecting the given sample.
   task automatic hs(input string tag, input logic [15:0] exp);
      req = 1'b1;
      tick();
      chk({tag, "_ack_hi"}, 32'(ack), 32'd1);
      chk({tag, "_data"}, 32'(data), 32'(exp));
      req = 1'b0;
      tick();
      chk({tag, "_ack_lo"}, 32'(ack), 32'd0);
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      rst      = 1'b1;
      wr_valid = 1'b0;
      wr_data  = '0;
      req      = 1'b0;

      // Reset state
      tick();
      tick();
      chk("rst_wr_ready", 32'(wr_ready), 32'd0);
      chk("rst_ack", 32'(ack), 32'd0);
      chk("rst_data", 32'(data), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_starve", 32'(starve), 32'd0);
      rst = 1'b0;
      #1;
      chk("post_rst_wr_ready", 32'(wr_ready), 32'd1);

      // Basic pull
      push(16'h1234);
      push(16'hABCD);
      chk("basic_level2", 32'(level), 32'd2);
      req = 1'b1;
      #1;
      chk("basic_ack_before", 32'(ack), 32'd0);
      tick();
      chk("basic_ack1", 32'(ack), 32'd1);
      chk("basic_data1", 32'(data), 32'h1234);
      chk("basic_level1", 32'(level), 32'd1);
      req = 1'b0;
      tick();
      chk("basic_ack1_lo", 32'(ack), 32'd0);
      chk("basic_data1_hold", 32'(data), 32'h1234);
      hs("basic2", 16'hABCD);
      chk("basic_level0", 32'(level), 32'd0);

      // Starve then serve
      req = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("starve_flag", 32'(starve), 32'd1);
         chk("starve_ack", 32'(ack), 32'd0);
      end
      wr_valid = 1'b1;
      wr_data  = 16'h00FF;
      tick();
      wr_valid = 1'b0;
      chk("starve_nofall_ack", 32'(ack), 32'd0);
      chk("starve_nofall_level", 32'(level), 32'd1);
      chk("starve_cleared", 32'(starve), 32'd0);
      tick();
      chk("starve_served_ack", 32'(ack), 32'd1);
      chk("starve_served_data", 32'(data), 32'h00FF);
      chk("starve_served_flag", 32'(starve), 32'd0);
      chk("starve_served_level", 32'(level), 32'd0);
      req = 1'b0;
      tick();
      chk("starve_release", 32'(ack), 32'd0);

      // Full FIFO
      wr_valid = 1'b1;
      for (int i = 0; i < 16; i++) begin
         wr_data = 16'h0100 + 16'(i);
         tick();
      end
      wr_data = 16'h0200;
      #1;
      chk("full_level", 32'(level), 32'd16);
      chk("full_wr_ready", 32'(wr_ready), 32'd0);
      tick();
      tick();
      chk("full_level_hold", 32'(level), 32'd16);
      req = 1'b1;
      tick();
      chk("full_pop_ack", 32'(ack), 32'd1);
      chk("full_pop_data", 32'(data), 32'h0100);
      chk("full_pop_level", 32'(level), 32'd15);
      chk("full_ready_again", 32'(wr_ready), 32'd1);
      req = 1'b0;
      tick();
      wr_valid = 1'b0;
      chk("full_17th_level", 32'(level), 32'd16);
      for (int i = 1; i < 16; i++) begin
         hs("full_order", 16'h0100 + 16'(i));
      end
      hs("full_17th", 16'h0200);
      chk("full_drained", 32'(level), 32'd0);

      // Simultaneous push/pop across pointer wrap
      for (int i = 0; i < 8; i++) begin
         push(16'h3000 + 16'(i));
      end
      chk("wrap_level_init", 32'(level), 32'd8);
      for (int j = 0; j < 40; j++) begin
         req      = 1'b1;
         wr_valid = 1'b1;
         wr_data  = 16'h3008 + 16'(j);
         tick();
         wr_valid = 1'b0;
         chk("wrap_data", 32'(data), 32'h3000 + 32'(j));
         chk("wrap_level", 32'(level), 32'd8);
         req = 1'b0;
         tick();
         chk("wrap_ack_lo", 32'(ack), 32'd0);
      end
      for (int i = 0; i < 5; i++) begin
         hs("wrap_drain", 16'h3028 + 16'(i));
      end
      chk("held_level3", 32'(level), 32'd3);

      // Held req
      req = 1'b1;
      tick();
      for (int i = 0; i < 10; i++) begin
         chk("held_ack", 32'(ack), 32'd1);
         chk("held_data", 32'(data), 32'h302D);
         chk("held_level", 32'(level), 32'd2);
         tick();
      end
      req = 1'b0;
      tick();
      chk("held_release", 32'(ack), 32'd0);
      chk("held_level_after", 32'(level), 32'd2);

      // Reset mid-handshake
      push(16'h4001);
      push(16'h4002);
      push(16'h4003);
      req = 1'b1;
      tick();
      chk("midrst_ack_pre", 32'(ack), 32'd1);
      chk("midrst_data_pre", 32'(data), 32'h302E);
      chk("midrst_level_pre", 32'(level), 32'd4);
      rst = 1'b1;
      #1;
      chk("midrst_wr_ready_in", 32'(wr_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      chk("midrst_ack", 32'(ack), 32'd0);
      chk("midrst_data", 32'(data), 32'd0);
      chk("midrst_level", 32'(level), 32'd0);
      chk("midrst_wr_ready_out", 32'(wr_ready), 32'd1);
      chk("midrst_starve", 32'(starve), 32'd1);
      tick();
      chk("midrst_wait_ack", 32'(ack), 32'd0);
      push(16'h5555);
      chk("midrst_push_ack", 32'(ack), 32'd0);
      tick();
      chk("midrst_serve_ack", 32'(ack), 32'd1);
      chk("midrst_serve_data", 32'(data), 32'h5555);
      req = 1'b0;
      tick();
      chk("midrst_serve_release", 32'(ack), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
